// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Forwarding selects, pipeline stalls and a single-entry long-latency
//   scoreboard for the ID stage.
//
// Ports:
//   clk, rst                synchronous active-high reset
//   IF_ID_*                 instruction currently in ID (opcode, rs1/rs2/rd,
//                           rd write enable, long-op flag)
//   ID_EX_*, EX_MEM_*,
//   MEM_WB_*                destination and control of older instructions
//   stall_cnt_clr           clears stall_cycles
//   forwardA/forwardB       EX operand select (10 EX/MEM, 01 MEM/WB, 00 RF)
//   forward_comp1/2         ID branch-compare select, same encoding
//   stall                   hold PC and IF/ID, bubble into ID/EX
//   long_busy/long_wb/
//   long_rd                 long-op scoreboard state
//   stall_cycles            saturating count of stalled cycles
module hazard_forward_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LONG_LAT       = 4,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rd,
  input  logic                      IF_ID_reg_wr_en,
  input  logic                      IF_ID_long_op,
  input  logic                      ID_EX_reg_wr_en,
  input  logic                      ID_EX_mem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      EX_MEM_reg_wr_en,
  input  logic                      EX_MEM_mem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  input  logic                      MEM_WB_reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
  input  logic                      stall_cnt_clr,
  output logic [1:0]                forwardA,
  output logic [1:0]                forwardB,
  output logic [1:0]                forward_comp1,
  output logic [1:0]                forward_comp2,
  output logic                      stall,
  output logic                      long_busy,
  output logic                      long_wb,
  output logic [REG_ADDR_WIDTH-1:0] long_rd,
  output logic [STALL_CNT_W-1:0]    stall_cycles
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  // 8 bits covers the full legal latency range 2..255.
  localparam logic [7:0] LAT_INIT  = 8'(LONG_LAT);

  logic [7:0] cnt;
  logic       is_branch;
  logic       issue;

  // Producer with a live write to a non-zero register that equals the reader.
  function automatic logic match(input logic [REG_ADDR_WIDTH-1:0] rd,
                                 input logic [REG_ADDR_WIDTH-1:0] rs,
                                 input logic                      wr_en);
    return wr_en && (rd == rs) && (rd != '0);
  endfunction

  function automatic logic [1:0] ex_sel(input logic [REG_ADDR_WIDTH-1:0] rs,
                                        input logic [REG_ADDR_WIDTH-1:0] exm_rd,
                                        input logic                      exm_wr,
                                        input logic [REG_ADDR_WIDTH-1:0] mwb_rd,
                                        input logic                      mwb_wr);
    if (match(exm_rd, rs, exm_wr))      return 2'b10;
    else if (match(mwb_rd, rs, mwb_wr)) return 2'b01;
    else                                return 2'b00;
  endfunction

  assign is_branch = (IF_ID_inst_opcode == OP_BRANCH);

  // EX operand selects: the younger EX/MEM value wins over MEM/WB.
  assign forwardA = ex_sel(ID_EX_rs1, EX_MEM_rd, EX_MEM_reg_wr_en, MEM_WB_rd, MEM_WB_reg_wr_en);
  assign forwardB = ex_sel(ID_EX_rs2, EX_MEM_rd, EX_MEM_reg_wr_en, MEM_WB_rd, MEM_WB_reg_wr_en);

  // Branch compare selects. A load in EX/MEM has no data yet, so it cannot
  // feed the comparator; that case is covered by a stall instead.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    forward_comp1 = 2'b00;
    forward_comp2 = 2'b00;
    if (is_branch) begin
      forward_comp1 = ex_sel(IF_ID_rs1, EX_MEM_rd, EX_MEM_reg_wr_en && !EX_MEM_mem_rd,
                             MEM_WB_rd, MEM_WB_reg_wr_en);
      forward_comp2 = ex_sel(IF_ID_rs2, EX_MEM_rd, EX_MEM_reg_wr_en && !EX_MEM_mem_rd,
                             MEM_WB_rd, MEM_WB_reg_wr_en);
    end
  end

  always_comb begin
    logic load_use, br_ex, br_mem_load, long_raw, long_waw, long_struct;
    load_use    = ID_EX_mem_rd &&
                  (match(ID_EX_rd, IF_ID_rs1, ID_EX_reg_wr_en) ||
                   match(ID_EX_rd, IF_ID_rs2, ID_EX_reg_wr_en));
    br_ex       = is_branch &&
                  (match(ID_EX_rd, IF_ID_rs1, ID_EX_reg_wr_en) ||
                   match(ID_EX_rd, IF_ID_rs2, ID_EX_reg_wr_en));
    br_mem_load = is_branch && EX_MEM_mem_rd &&
                  (match(EX_MEM_rd, IF_ID_rs1, EX_MEM_reg_wr_en) ||
                   match(EX_MEM_rd, IF_ID_rs2, EX_MEM_reg_wr_en));
    long_raw    = long_busy && (long_rd != '0) &&
                  ((long_rd == IF_ID_rs1) || (long_rd == IF_ID_rs2));
    long_waw    = long_busy && IF_ID_reg_wr_en && (IF_ID_rd == long_rd);
    // Only one long op may be in flight; this also keeps issue and
    // writeback from ever landing on the same edge.
    long_struct = long_busy && IF_ID_long_op;
    stall = load_use || br_ex || br_mem_load || long_raw || long_waw || long_struct;
  end

  assign issue   = IF_ID_long_op && !stall;
  assign long_wb = long_busy && (cnt == 8'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      long_busy <= 1'b0;
      long_rd   <= '0;
      cnt       <= '0;
    end else if (issue) begin
      long_busy <= 1'b1;
      long_rd   <= IF_ID_rd;
      cnt       <= LAT_INIT;
    end else if (long_busy) begin
      if (cnt == 8'd1) begin
        long_busy <= 1'b0;
        cnt       <= '0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stall_cnt_clr)
      stall_cycles <= '0;
    else if (stall && !(&stall_cycles))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised successor to the pipeline's combinational forwarding logic: one unit that produces EX-stage and ID-stage (branch compare) forwarding selects, load-use and branch-dependency stalls, and a single-entry scoreboard for one in-flight long-latency operation (multiply/divide). The long unit writes through a dedicated second register-file write port. Sits beside the ID stage and drives PC/IF_ID hold and the ID_EX bubble.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register address width
- LONG_LAT, 4, long-op latency in cycles from issue to writeback edge; legal range 2..255
- STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- IF_ID_inst_opcode  in  7  opcode in ID; branch when 7'b1100011
- IF_ID_rs1 / IF_ID_rs2 / IF_ID_rd  in  REG_ADDR_WIDTH each  ID register fields
- IF_ID_reg_wr_en  in  1  ID instruction writes rd
- IF_ID_long_op  in  1  ID instruction is a long-latency op
- ID_EX_reg_wr_en, ID_EX_mem_rd  in  1 each  EX writes rd / EX is a load
- ID_EX_rs1 / ID_EX_rs2 / ID_EX_rd  in  REG_ADDR_WIDTH each
- EX_MEM_reg_wr_en, EX_MEM_mem_rd  in  1 each
- EX_MEM_rd  in  REG_ADDR_WIDTH
- MEM_WB_reg_wr_en  in  1;  MEM_WB_rd  in  REG_ADDR_WIDTH
- stall_cnt_clr  in  1  clears stall_cycles
- forwardA / forwardB  out  2  EX operand select: 10 EX/MEM, 01 MEM/WB, 00 reg file
- forward_comp1 / forward_comp2  out  2  ID compare select, same encoding
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- long_busy  out  1  long op in flight
- long_wb  out  1  long result written at end of this cycle
- long_rd  out  REG_ADDR_WIDTH  destination of in-flight long op
- stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles

## Operation
- "match(x,y)": x==y and x!=0 and corresponding wr_en=1.
- forwardA: 10 if match(EX_MEM_rd, ID_EX_rs1); else 01 if match(MEM_WB_rd, ID_EX_rs1); else 00. forwardB identical on rs2. EX/MEM has priority.
- forward_comp1/2 (branch in ID only, else 00): 10 if match(EX_MEM_rd, rsN) and !EX_MEM_mem_rd; else 01 if match(MEM_WB_rd, rsN); else 00.
- Stall sources (OR):
  - load-use: ID_EX_mem_rd and match(ID_EX_rd, IF_ID_rs1 or rs2)
  - branch-on-EX: branch and match(ID_EX_rd, rs1 or rs2)
  - branch-on-load-in-MEM: branch and EX_MEM_mem_rd and match(EX_MEM_rd, rs1 or rs2)
  - long RAW: long_busy and long_rd!=0 and long_rd equals IF_ID_rs1 or rs2
  - long WAW: long_busy and IF_ID_reg_wr_en and IF_ID_rd==long_rd
  - long structural: long_busy and IF_ID_long_op
- Scoreboard: issue = IF_ID_long_op & !stall. On issue: long_busy<=1, long_rd<=IF_ID_rd, cnt<=LONG_LAT. While busy, cnt decrements each cycle; long_wb = long_busy & cnt==1; at that edge long_busy<=0, cnt<=0. long_rd holds until next issue.
- Issue and clear cannot coincide (structural stall guarantees it).
- stall_cycles increments when stall=1, saturates at all-ones; stall_cnt_clr wins over increment.

## Timing
- Forward selects and stall are combinational from inputs and current state; zero latency.
- Reset: long_busy=0, long_wb=0, long_rd=0, cnt=0, stall_cycles=0; forward/stall outputs reflect inputs only. Reset mid-operation abandons the long op; no long_wb issued.
- Long op issued in cycle T: long_busy high T+1..T+LONG_LAT, long_wb high in T+LONG_LAT; dependent in ID released in T+LONG_LAT+1 and reads the written register file.
- Branch on ALU result: 1 stall cycle, then forward_comp=10. Branch on load: 2 stall cycles, then 01.
- Load-use: 1 stall cycle, then forwardA/B=01.

## Test plan
- add x5 in EX/MEM, sub using x5 in ID/EX with x5 also in MEM/WB -> forwardA=10 (priority); x0 as rd -> forwardA=00.
- lw x6 in ID/EX, add x7,x6,x1 in ID -> stall=1 one cycle, next cycle forwardA=01, stall_cycles=1.
- beq x8 after lw x8 -> stall two consecutive cycles, then forward_comp1=01; beq after add x8 -> one stall, then forward_comp1=10.
- LONG_LAT=4, mul x9 issued cycle 0, add x10,x9,x2 in ID -> stall cycles 1-4, long_wb=1 at cycle 4, released cycle 5; second mul in ID at cycle 2 -> stalled until cycle 5.
- rst asserted at cycle 2 of a long op -> long_busy=0, stall_cycles=0 next cycle, no long_wb.
- Force 2^STALL_CNT_W+3 stall cycles -> stall_cycles stays all-ones; stall_cnt_clr with stall=1 -> 0.
